wmem_dispatch_ctrl: RTL and testbench
=====================================

Name: wmem_dispatch_ctrl

Overview:
- Clocked controller that sequences the filter (weight) memory.
- Steers the 25-word load phase into the filter SRAM write port.
- Then reads the filter back row by row and packs two weight packets per PPE for PPE IDs 5..9.
- After the last weight packet, emits one weights-done packet to IMEM (ID 11). A rerun pulse replays dispatch from stored weights without reloading.

Parameters:
- FILTER_SIZE, 5, filter is FILTER_SIZE x FILTER_SIZE words.
- WEIGHT_WIDTH, 8, bits per weight.
- ADDR_W, 5, filter SRAM address width.
- PKT_WIDTH, 33, packet width; [32:29] dest, [28:25] opcode, [24:0] data.
- FIRST_PPE, 5, dest ID of PPE receiving row 0.
- IMEM_ID, 11, dest ID for the weights-done packet.
- OP_WEIGHT, 0, opcode for weight packets and for the done packet.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- load_start  in  1  one-cycle pulse; opens the load phase.
- wr_valid  in  1  load write strobe.
- wr_addr  in  ADDR_W  load address.
- wr_data  in  WEIGHT_WIDTH  load data.
- load_done  in  1  one-cycle pulse; closes load, starts dispatch.
- rerun  in  1  one-cycle pulse; replays dispatch.
- mem_we  out  1  SRAM write enable.
- mem_waddr  out  ADDR_W  SRAM write address.
- mem_wdata  out  WEIGHT_WIDTH  SRAM write data.
- mem_re  out  1  SRAM read enable.
- mem_raddr  out  ADDR_W  SRAM read address.
- mem_rdata  in  WEIGHT_WIDTH  SRAM read data, valid 1 cycle after mem_re.
- pkt_valid  out  1  packet valid to router.
- pkt_ready  in  1  router accept.
- pkt_data  out  PKT_WIDTH  packet.
- busy  out  1  high in any state other than IDLE and READY.
- done  out  1  one-cycle pulse when the done packet is accepted.
- err  out  2  sticky: [0] write address >= 25, [1] load closed with count != 25.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; row, word and write counters 0; err cleared.
  - Reset mid-operation abandons any pending packet; no partial packet is retained.
- States: IDLE, LOAD, FETCH, SEND_A, SEND_B, SEND_DONE, READY.
- IDLE:
  - load_start -> LOAD; clears err and the write count.
  - rerun is ignored in IDLE.
- LOAD:
  - Each wr_valid with addr < 25 drives mem_we/mem_waddr/mem_wdata combinationally in the same cycle and increments the write count.
  - wr_valid with addr >= 25 is dropped and sets err[0].
  - On load_done: -> FETCH with row = 0. If the write count, including a same-cycle write, is not 25, set err[1]; dispatch proceeds regardless.
- FETCH:
  - Issues mem_re for addresses row*5+0..row*5+4, one per cycle, over 5 consecutive cycles.
  - Captures mem_rdata one cycle later into a 5 x 8 buffer.
  - Goes to SEND_A in the cycle after the last capture.
  - First pkt_valid rises exactly 7 cycles after the cycle in which load_done is sampled.
- SEND_A:
  - pkt_data = {FIRST_PPE+row, OP_WEIGHT, 1'b0, w2, w1, w0}.
  - On pkt_valid & pkt_ready -> SEND_B.
- SEND_B:
  - pkt_data = {FIRST_PPE+row, OP_WEIGHT, 9'b0, w4, w3}.
  - On accept: if row == 4 -> SEND_DONE; otherwise row++ and -> FETCH.
- Handshake rules:
  - pkt_valid stays high and pkt_data holds stable while pkt_ready is low; no timeout.
  - pkt_valid drops for at least the FETCH cycles between rows.
- SEND_DONE:
  - pkt_data = {IMEM_ID, OP_WEIGHT, 25'b0}.
  - On accept: done pulses and the state goes to READY.
- READY:
  - rerun -> FETCH with row = 0, giving the same 11-packet sequence.
  - load_start -> LOAD.
  - If both arrive in the same cycle, load_start wins.
- load_start, load_done and rerun are ignored in FETCH and in all SEND states.
- Dest field is 4 bits; FIRST_PPE+row must not exceed 15 (elaboration check).
- Total per dispatch: 10 weight packets plus 1 done packet.

Decomposition:
- Shared package: packet field bit positions, PKT_WIDTH, OP_WEIGHT, OP_TIMESTEP_DONE = 15, IMEM_ID, FIRST_PPE, WEIGHT_WIDTH, FILTER_SIZE, and the state enum typedef.
- Sub-module wdc_pkt_pack: combinational packer from (dest, opcode, up to three weights) to pkt_data, reused by the ifmap and output-memory controllers.
- Sequencer and counters stay in wmem_dispatch_ctrl.

Test Plan:
1. Load weights w[k] = k+1 at addresses 0..24, then load_done, with pkt_ready held at 1:
   - 11 packets in order.
   - First packet 0x{5,0,0x030201}, second 0x{5,0,0x0504}, ..., last weight packet dest 9 data 0x1918.
   - Then dest 11 with data 0; done pulses once; err = 0.
2. Drive pkt_ready low for 4 cycles on every packet: pkt_data is stable across each stall, and the sequence and count are identical to scenario 1.
3. Load 24 writes plus one write to address 30, then load_done: err = 2'b11, and dispatch still emits 11 packets.
4. Issue rerun in READY after scenario 1: the identical 11-packet sequence repeats with no SRAM writes. A rerun issued mid-dispatch has no effect.
5. Assert reset during the SEND_B of row 2: outputs are 0 next cycle and the state is IDLE. A fresh load then gives a full correct sequence starting at dest 5.
6. Load 24 writes, with the 25th write in the same cycle as load_done: it is counted, err[1] stays 0, and the SRAM is written.

Source files
------------

// File: rtl/wmem_dispatch_ctrl_pkg.sv
// Shared constants, packet field layout and sequencer state for the filter-memory controller.
package wmem_dispatch_ctrl_pkg;

    localparam int unsigned FILTER_SIZE  = 5;
    localparam int unsigned FILTER_WORDS = FILTER_SIZE * FILTER_SIZE;
    localparam int unsigned WEIGHT_WIDTH = 8;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned PKT_WIDTH    = 33;

    // Packet layout: [32:29] dest, [28:25] opcode, [24:0] data
    localparam int unsigned DEST_W     = 4;
    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned DATA_W     = 25;
    localparam int unsigned DEST_LSB   = 29;
    localparam int unsigned OPCODE_LSB = 25;
    localparam int unsigned DATA_LSB   = 0;

    localparam logic [DEST_W-1:0]   FIRST_PPE        = 4'd5;
    localparam logic [DEST_W-1:0]   IMEM_ID          = 4'd11;
    localparam logic [OPCODE_W-1:0] OP_WEIGHT        = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_TIMESTEP_DONE = 4'd15;

    typedef logic [WEIGHT_WIDTH-1:0] weight_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StSendA,
        StSendB,
        StSendDone,
        StReady
    } wdc_state_e;

    // Row r of the filter is owned by PPE FIRST_PPE + r.
    function automatic logic [DEST_W-1:0] row_dest(input logic [2:0] row);
        return FIRST_PPE + DEST_W'(row);
    endfunction

endpackage

// File: rtl/wmem_dispatch_ctrl_if.sv
// Filter SRAM port and router packet port of the weight-memory controller.
interface wmem_dispatch_ctrl_if;
    import wmem_dispatch_ctrl_pkg::*;

    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_waddr;
    logic [WEIGHT_WIDTH-1:0] mem_wdata;
    logic                    mem_re;
    logic [ADDR_W-1:0]       mem_raddr;
    logic [WEIGHT_WIDTH-1:0] mem_rdata;
    logic                    pkt_valid;
    logic                    pkt_ready;
    logic [PKT_WIDTH-1:0]    pkt_data;

    // Controller side
    modport master (
        output mem_we,
        output mem_waddr,
        output mem_wdata,
        output mem_re,
        output mem_raddr,
        input  mem_rdata,
        output pkt_valid,
        input  pkt_ready,
        output pkt_data
    );

    // SRAM and router side
    modport slave (
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata,
        input  mem_re,
        input  mem_raddr,
        output mem_rdata,
        input  pkt_valid,
        output pkt_ready,
        input  pkt_data
    );

endinterface

// File: rtl/wdc_pkt_pack.sv
// Combinational packet packer: dest, opcode and up to three weights into one router packet.
module wdc_pkt_pack
    import wmem_dispatch_ctrl_pkg::*;
(
    input  logic [DEST_W-1:0]       dest,
    input  logic [OPCODE_W-1:0]     opcode,
    input  logic [WEIGHT_WIDTH-1:0] w0,
    input  logic [WEIGHT_WIDTH-1:0] w1,
    input  logic [WEIGHT_WIDTH-1:0] w2,
    output logic [PKT_WIDTH-1:0]    pkt_data
);

    // Weights fill the low data bits, w0 least significant; unused data bits stay zero
    always_comb begin
        pkt_data                                = '0;
        pkt_data[DEST_LSB +: DEST_W]            = dest;
        pkt_data[OPCODE_LSB +: OPCODE_W]        = opcode;
        pkt_data[DATA_LSB +: 3 * WEIGHT_WIDTH]  = {w2, w1, w0};
    end

endmodule

// File: rtl/wmem_dispatch_ctrl.sv
// Filter-memory controller: steers the weight load into the SRAM, then reads it back row by
// row and dispatches two weight packets per PPE followed by one weights-done packet to IMEM.
module wmem_dispatch_ctrl
    import wmem_dispatch_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic                    wr_valid,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WEIGHT_WIDTH-1:0] wr_data,
    input  logic                    load_done,
    input  logic                    rerun,
    wmem_dispatch_ctrl_if.master    bus,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err
);

    localparam logic [ADDR_W-1:0] FULL_COUNT = ADDR_W'(FILTER_WORDS);
    localparam logic [2:0]        LAST_WORD  = 3'(FILTER_SIZE);
    localparam logic [2:0]        LAST_ROW   = 3'(FILTER_SIZE - 1);

    // The 4-bit dest field must be able to address every row's PPE.
    if (int'(FIRST_PPE) + int'(FILTER_SIZE) - 1 > 15) begin : gen_dest_range_check
        $error("FIRST_PPE + FILTER_SIZE - 1 exceeds the 4-bit dest field");
    end

    wdc_state_e state_q, state_d;

    logic [2:0]        row_q;
    logic [2:0]        word_q;   // FETCH step: issue word_q, capture word_q-1
    logic [ADDR_W-1:0] wcnt_q;
    logic [1:0]        err_q;
    weight_t           wbuf_q [FILTER_SIZE];

    logic              wr_in_range;
    logic              wr_accept;
    logic              wr_drop;
    logic              close_load;
    logic [ADDR_W-1:0] wcnt_final;
    logic              start_load;
    logic              start_rerun;
    logic              send_state;
    logic              pkt_accept;

    logic [DEST_W-1:0]    pk_dest;
    weight_t              pk_w0, pk_w1, pk_w2;
    logic [PKT_WIDTH-1:0] pk_data;

    assign wr_in_range = wr_addr < FULL_COUNT;
    assign wr_accept   = (state_q == StLoad) && wr_valid && wr_in_range;
    assign wr_drop     = (state_q == StLoad) && wr_valid && !wr_in_range;
    assign close_load  = (state_q == StLoad) && load_done;
    // A write landing in the same cycle as load_done still counts toward the full filter
    assign wcnt_final  = wcnt_q + ADDR_W'(wr_accept);
    assign start_load  = ((state_q == StIdle) || (state_q == StReady)) && load_start;
    // load_start has priority over rerun in READY
    assign start_rerun = (state_q == StReady) && rerun && !load_start;
    assign send_state  = (state_q == StSendA) || (state_q == StSendB) ||
                         (state_q == StSendDone);
    assign pkt_accept  = send_state && bus.pkt_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_load) state_d = StLoad;
            end
            StLoad: begin
                if (close_load) state_d = StFetch;
            end
            StFetch: begin
                if (word_q == LAST_WORD) state_d = StSendA;
            end
            StSendA: begin
                if (pkt_accept) state_d = StSendB;
            end
            StSendB: begin
                if (pkt_accept) state_d = (row_q == LAST_ROW) ? StSendDone : StFetch;
            end
            StSendDone: begin
                if (pkt_accept) state_d = StReady;
            end
            StReady: begin
                if (start_load) begin
                    state_d = StLoad;
                end else if (start_rerun) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Row/word/write counters, sticky error flags and the fetched row buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q  <= '0;
            word_q <= '0;
            wcnt_q <= '0;
            err_q  <= '0;
            for (int i = 0; i < int'(FILTER_SIZE); i++) begin
                wbuf_q[i] <= '0;
            end
        end else begin
            if (start_load) begin
                wcnt_q <= '0;
                err_q  <= '0;
            end
            // Saturate so a runaway load can never wrap back to a "full" count
            if (wr_accept && (wcnt_q != '1)) begin
                wcnt_q <= wcnt_q + ADDR_W'(1);
            end
            if (wr_drop) begin
                err_q[0] <= 1'b1;
            end
            if (close_load) begin
                row_q  <= '0;
                word_q <= '0;
                if (wcnt_final != FULL_COUNT) err_q[1] <= 1'b1;
            end
            if (start_rerun) begin
                row_q  <= '0;
                word_q <= '0;
            end
            if (state_q == StFetch) begin
                word_q <= (word_q == LAST_WORD) ? 3'd0 : word_q + 3'd1;
                if (word_q != 3'd0) begin
                    wbuf_q[word_q - 3'd1] <= bus.mem_rdata;
                end
            end
            if ((state_q == StSendB) && pkt_accept && (row_q != LAST_ROW)) begin
                row_q <= row_q + 3'd1;
            end
        end
    end

    // Output decode: SRAM strobes, packet fields, status
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        bus.mem_re    = 1'b0;
        bus.mem_raddr = '0;
        bus.pkt_valid = 1'b0;
        pk_dest       = '0;
        pk_w0         = '0;
        pk_w1         = '0;
        pk_w2         = '0;
        done          = 1'b0;
        busy          = (state_q != StIdle) && (state_q != StReady);
        unique case (state_q)
            StLoad: begin
                if (wr_accept) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = wr_addr;
                    bus.mem_wdata = wr_data;
                end
            end
            StFetch: begin
                if (word_q != LAST_WORD) begin
                    bus.mem_re    = 1'b1;
                    bus.mem_raddr = ADDR_W'(32'(row_q) * FILTER_SIZE + 32'(word_q));
                end
            end
            StSendA: begin
                bus.pkt_valid = 1'b1;
                pk_dest       = row_dest(row_q);
                pk_w0         = wbuf_q[0];
                pk_w1         = wbuf_q[1];
                pk_w2         = wbuf_q[2];
            end
            StSendB: begin
                bus.pkt_valid = 1'b1;
                pk_dest       = row_dest(row_q);
                pk_w0         = wbuf_q[3];
                pk_w1         = wbuf_q[4];
            end
            StSendDone: begin
                bus.pkt_valid = 1'b1;
                pk_dest       = IMEM_ID;
                done          = bus.pkt_ready;
            end
            default: ;
        endcase
    end

    assign err = err_q;

    wdc_pkt_pack u_pkt_pack (
        .dest     (pk_dest),
        .opcode   (OP_WEIGHT),
        .w0       (pk_w0),
        .w1       (pk_w1),
        .w2       (pk_w2),
        .pkt_data (pk_data)
    );

    assign bus.pkt_data = bus.pkt_valid ? pk_data : '0;

endmodule

// File: tb/tb_wmem_dispatch_ctrl.sv
// Self-checking bench for wmem_dispatch_ctrl: SRAM model, randomized loads and stalls,
// expected packets computed from the filter contents.
module tb_wmem_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       wr_valid;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       load_done;
    logic       rerun;
    logic       busy;
    logic       done;
    logic [1:0] err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ld_w    [25];
    logic [7:0]  exp_mem [25];
    logic [32:0] got     [$];

    logic [7:0] sram [32];
    int         sram_wr_cnt = 0;

    always #5 clk = ~clk;

    wmem_dispatch_ctrl_if bus_if ();

    wmem_dispatch_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .rerun      (rerun),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Filter SRAM: one-cycle read latency
    always @(posedge clk) begin
        if (bus_if.mem_we) begin
            sram[bus_if.mem_waddr] <= bus_if.mem_wdata;
            sram_wr_cnt <= sram_wr_cnt + 1;
        end
        if (bus_if.mem_re) bus_if.mem_rdata <= sram[bus_if.mem_raddr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Packet idx of a dispatch: 0..9 weight packets (two per row), 10 the IMEM done packet
    function automatic logic [32:0] exp_pkt(input int idx);
        int r;
        r = idx / 2;
        if (idx >= 10) return {4'd11, 4'd0, 25'd0};
        if (idx % 2 == 0)
            return {4'(5 + r), 4'd0, 1'b0, exp_mem[5*r+2], exp_mem[5*r+1], exp_mem[5*r]};
        return {4'(5 + r), 4'd0, 9'd0, exp_mem[5*r+4], exp_mem[5*r+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_weights();
        for (int k = 0; k < 25; k++) ld_w[k] = 8'($urandom);
    endtask

    // Writes ld_w to addresses 0..n_writes-1; optionally one out-of-range write, optionally
    // load_done together with the last write. Returns in the first cycle after load_done.
    task automatic load_weights(input int n_writes, input bit bad_write, input bit done_with_last,
                                input bit gaps);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < n_writes; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(i);
            wr_data  = ld_w[i];
            exp_mem[i] = ld_w[i];
            if (done_with_last && i == n_writes - 1) load_done = 1'b1;
            tick();
            wr_valid = 1'b0;
            if (gaps && i < n_writes - 1 && $urandom_range(3) == 0) tick();
        end
        if (bad_write) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(25 + $urandom_range(6));
            wr_data  = 8'($urandom);
            tick();
            wr_valid = 1'b0;
        end
        if (!done_with_last) begin
            load_done = 1'b1;
            tick();
        end
        load_done = 1'b0;
    endtask

    // Called in the first cycle after load_done/rerun was sampled (cycle 1). Collects accepted
    // packets, checks every presented packet against the model, stalls each packet for
    // `stall` cycles, pulses load_start+rerun at cycle poke_cyc, stops early after abort_pkts.
    task automatic run_dispatch(input int stall, input int poke_cyc, input int abort_pkts,
                                output int first_valid, output int done_cnt);
        int cyc;
        int stall_cnt;
        int n_exp;
        got.delete();
        first_valid = -1;
        done_cnt    = 0;
        stall_cnt   = 0;
        cyc         = 1;
        n_exp       = (abort_pkts > 0) ? abort_pkts : 11;
        bus_if.pkt_ready = (stall == 0);
        while (got.size() < n_exp && cyc < 400) begin
            @(negedge clk);
            if (bus_if.pkt_valid) begin
                if (first_valid < 0) first_valid = cyc;
                n_checks++;
                if (bus_if.pkt_data !== exp_pkt(got.size())) begin
                    n_errors++;
                    $display("FAIL pkt_data[%0d] cycle %0d: got %h required %h",
                             got.size(), cyc, bus_if.pkt_data, exp_pkt(got.size()));
                end
                if (bus_if.pkt_ready) begin
                    got.push_back(bus_if.pkt_data);
                    stall_cnt = 0;
                end else begin
                    stall_cnt++;
                end
            end
            if (done) done_cnt++;
            tick();
            cyc++;
            bus_if.pkt_ready = (stall_cnt >= stall);
            load_start = (cyc == poke_cyc);
            rerun      = (cyc == poke_cyc);
        end
        load_start = 1'b0;
        rerun      = 1'b0;
        if (got.size() < n_exp) begin
            n_checks++;
            n_errors++;
            $display("FAIL dispatch_timeout: got %0d packets, required %0d", got.size(), n_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, bus_if.pkt_valid, bus_if.mem_we, bus_if.mem_re} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b err=%b valid=%b we=%b re=%b required 0",
                     busy, done, err, bus_if.pkt_valid, bus_if.mem_we, bus_if.mem_re);
        end
        n_checks++;
        if ({bus_if.pkt_data, bus_if.mem_waddr, bus_if.mem_wdata, bus_if.mem_raddr} !== 51'b0) begin
            n_errors++;
            $display("FAIL reset_data: got pkt=%h waddr=%h wdata=%h raddr=%h required 0",
                     bus_if.pkt_data, bus_if.mem_waddr, bus_if.mem_wdata, bus_if.mem_raddr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int fv, dc, w0;
        for (int k = 0; k < 25; k++) ld_w[k] = 8'(k + 1);
        w0 = sram_wr_cnt;
        load_weights(25, 1'b0, 1'b0, 1'b0);
        run_dispatch(0, 0, 0, fv, dc);
        n_checks++;
        if (got.size() != 11) begin
            n_errors++;
            $display("FAIL basic_count: got %0d required 11", got.size());
        end
        n_checks++;
        if (got[0] !== {4'd5, 4'd0, 25'h030201}) begin
            n_errors++;
            $display("FAIL basic_first: got %h required %h", got[0], {4'd5, 4'd0, 25'h030201});
        end
        n_checks++;
        if (got[1] !== {4'd5, 4'd0, 25'h0504}) begin
            n_errors++;
            $display("FAIL basic_second: got %h required %h", got[1], {4'd5, 4'd0, 25'h0504});
        end
        n_checks++;
        if (got[9] !== {4'd9, 4'd0, 25'h1918}) begin
            n_errors++;
            $display("FAIL basic_last_weight: got %h required %h", got[9], {4'd9, 4'd0, 25'h1918});
        end
        n_checks++;
        if (got[10] !== {4'd11, 4'd0, 25'h0}) begin
            n_errors++;
            $display("FAIL basic_done_pkt: got %h required %h", got[10], {4'd11, 4'd0, 25'h0});
        end
        n_checks++;
        if (fv != 7) begin
            n_errors++;
            $display("FAIL basic_latency: got %0d required 7", fv);
        end
        n_checks++;
        if (dc != 1) begin
            n_errors++;
            $display("FAIL basic_done_pulses: got %0d required 1", dc);
        end
        n_checks++;
        if (sram_wr_cnt - w0 != 25) begin
            n_errors++;
            $display("FAIL basic_sram_writes: got %0d required 25", sram_wr_cnt - w0);
        end
        @(negedge clk);
        n_checks++;
        if ({err, busy, bus_if.pkt_valid} !== 4'b0) begin
            n_errors++;
            $display("FAIL basic_ready_state: got err=%b busy=%b valid=%b required 0",
                     err, busy, bus_if.pkt_valid);
        end
    endtask

    task automatic test_stall();
        int fv, dc;
        for (int k = 0; k < 25; k++) ld_w[k] = 8'(k + 1);
        load_weights(25, 1'b0, 1'b0, 1'b0);
        run_dispatch(4, 0, 0, fv, dc);
        n_checks++;
        if (got.size() != 11 || dc != 1 || fv != 7) begin
            n_errors++;
            $display("FAIL stall_summary: got count=%0d done=%0d latency=%0d required 11/1/7",
                     got.size(), dc, fv);
        end
        n_checks++;
        if (err !== 2'b00) begin
            n_errors++;
            $display("FAIL stall_err: got %b required 00", err);
        end
    endtask

    task automatic test_rerun();
        int fv, dc, w0;
        w0 = sram_wr_cnt;
        rerun = 1'b1;
        tick();
        rerun = 1'b0;
        // load_start and rerun are pulsed again at cycle 8 (SEND_B of row 0) and must be ignored
        run_dispatch(0, 8, 0, fv, dc);
        n_checks++;
        if (got.size() != 11 || dc != 1 || fv != 7) begin
            n_errors++;
            $display("FAIL rerun_summary: got count=%0d done=%0d latency=%0d required 11/1/7",
                     got.size(), dc, fv);
        end
        n_checks++;
        if (got[0] !== {4'd5, 4'd0, 25'h030201}) begin
            n_errors++;
            $display("FAIL rerun_first: got %h required %h", got[0], {4'd5, 4'd0, 25'h030201});
        end
        n_checks++;
        if (sram_wr_cnt != w0) begin
            n_errors++;
            $display("FAIL rerun_sram_writes: got %0d required 0", sram_wr_cnt - w0);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rerun_busy_after: got %b required 0", busy);
        end
    endtask

    task automatic test_bad_load();
        int fv, dc, w0;
        randomize_weights();
        w0 = sram_wr_cnt;
        load_weights(24, 1'b1, 1'b0, 1'b1);
        run_dispatch(1, 0, 0, fv, dc);
        n_checks++;
        if (err !== 2'b11) begin
            n_errors++;
            $display("FAIL bad_load_err: got %b required 11", err);
        end
        n_checks++;
        if (got.size() != 11 || dc != 1) begin
            n_errors++;
            $display("FAIL bad_load_dispatch: got count=%0d done=%0d required 11/1", got.size(), dc);
        end
        n_checks++;
        if (sram_wr_cnt - w0 != 24) begin
            n_errors++;
            $display("FAIL bad_load_sram_writes: got %0d required 24", sram_wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        int fv, dc;
        randomize_weights();
        load_weights(24, 1'b1, 1'b0, 1'b0);
        // Stop after 5 packets: row 2 is now presenting its SEND_B packet
        run_dispatch(0, 0, 5, fv, dc);
        @(negedge clk);
        n_checks++;
        if (bus_if.pkt_valid !== 1'b1 || bus_if.pkt_data !== exp_pkt(5)) begin
            n_errors++;
            $display("FAIL reset_mid_pre: got valid=%b pkt=%h required 1/%h",
                     bus_if.pkt_valid, bus_if.pkt_data, exp_pkt(5));
        end
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, bus_if.pkt_valid, bus_if.mem_we, bus_if.mem_re} !== 7'b0 ||
            bus_if.pkt_data !== 33'b0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b err=%b valid=%b pkt=%h required 0",
                     busy, done, err, bus_if.pkt_valid, bus_if.pkt_data);
        end
        reset = 1'b0;
        tick();
        rerun = 1'b1;
        tick();
        rerun = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || bus_if.mem_re !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_rerun_ignored: got busy=%b re=%b required 0/0", busy, bus_if.mem_re);
        end
        randomize_weights();
        load_weights(25, 1'b0, 1'b0, 1'b1);
        run_dispatch(0, 0, 0, fv, dc);
        n_checks++;
        if (got.size() != 11 || dc != 1 || fv != 7 || got[0][32:29] !== 4'd5) begin
            n_errors++;
            $display("FAIL reset_mid_reload: got count=%0d done=%0d latency=%0d dest0=%0d required 11/1/7/5",
                     got.size(), dc, fv, got[0][32:29]);
        end
    endtask

    task automatic test_same_cycle();
        int fv, dc, w0;
        randomize_weights();
        w0 = sram_wr_cnt;
        load_weights(25, 1'b0, 1'b1, 1'b1);
        run_dispatch(0, 0, 0, fv, dc);
        n_checks++;
        if (err !== 2'b00) begin
            n_errors++;
            $display("FAIL same_cycle_err: got %b required 00", err);
        end
        n_checks++;
        if (sram_wr_cnt - w0 != 25) begin
            n_errors++;
            $display("FAIL same_cycle_sram_writes: got %0d required 25", sram_wr_cnt - w0);
        end
        n_checks++;
        if (got.size() != 11 || dc != 1 || fv != 7) begin
            n_errors++;
            $display("FAIL same_cycle_dispatch: got count=%0d done=%0d latency=%0d required 11/1/7",
                     got.size(), dc, fv);
        end
    endtask

    task automatic test_random();
        int fv, dc, st, poke;
        for (int it = 0; it < 3; it++) begin
            randomize_weights();
            load_weights(25, 1'b0, 1'b0, 1'b1);
            st   = $urandom_range(3);
            poke = $urandom_range(40, 2);
            run_dispatch(st, poke, 0, fv, dc);
            n_checks++;
            if (got.size() != 11 || dc != 1 || fv != 7 || err !== 2'b00) begin
                n_errors++;
                $display("FAIL random_load[%0d]: got count=%0d done=%0d latency=%0d err=%b required 11/1/7/00",
                         it, got.size(), dc, fv, err);
            end
            rerun = 1'b1;
            tick();
            rerun = 1'b0;
            run_dispatch($urandom_range(2), 0, 0, fv, dc);
            n_checks++;
            if (got.size() != 11 || dc != 1 || fv != 7) begin
                n_errors++;
                $display("FAIL random_rerun[%0d]: got count=%0d done=%0d latency=%0d required 11/1/7",
                         it, got.size(), dc, fv);
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        load_start       = 1'b0;
        wr_valid         = 1'b0;
        wr_addr          = '0;
        wr_data          = '0;
        load_done        = 1'b0;
        rerun            = 1'b0;
        bus_if.pkt_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_rerun();
        test_bad_load();
        test_reset_mid();
        test_same_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
